// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decryption round sequencer: operation
// codes driven to the datapath, controller states and round geometry.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int IMC_COLS   = 4;

  typedef enum logic [2:0] {
    OP_HOLD      = 3'd0,
    OP_LOAD_MSG  = 3'd1,
    OP_ADD_RK    = 3'd2,
    OP_INV_SHIFT = 3'd3,
    OP_INV_SUB   = 3'd4,
    OP_INV_MIX   = 3'd5
  } aes_op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_KEYEXP   = 4'd2,
    ST_ARK_INIT = 4'd3,
    ST_ISR      = 4'd4,
    ST_ISB      = 4'd5,
    ST_ARK      = 4'd6,
    ST_IMC      = 4'd7,
    ST_FIN_ISR  = 4'd8,
    ST_FIN_ISB  = 4'd9,
    ST_FIN_ARK  = 4'd10,
    ST_DONE     = 4'd11
  } aes_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Control sequencer for iterative AES-128 decryption: walks the inverse
// cipher rounds one datapath operation per cycle, driving op/key/column selects.
module aes_round_sequencer
  import aes_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       KEY_EXP_START,
  input  logic       KEY_EXP_DONE,
  output logic [2:0] OP_SEL,
  output logic       STATE_LD,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] MIX_COL_IDX,
  output logic       BUSY
);

  localparam logic [3:0] LAST_KEY = 4'(NUM_ROUNDS);
  localparam logic [1:0] LAST_COL = 2'(IMC_COLS - 1);

  aes_state_e r_state;
  aes_state_e w_next_state;
  logic [3:0] r_round;
  logic [1:0] r_col;

  aes_op_e    w_op;
  logic [3:0] w_round_idx;
  logic [1:0] w_mix_col;
  logic       w_key_start;
  logic       w_done;
  logic       w_busy;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_ARK_INIT)
        r_round <= LAST_KEY - 4'd1;
      else if (r_state == ST_IMC && r_col == LAST_COL && r_round > 4'd1)
        r_round <= r_round - 4'd1;
      // Column index wraps naturally after the last column of a round.
      r_col <= (r_state == ST_IMC) ? r_col + 2'd1 : 2'd0;
    end
  end

  // NOTE: w_next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (AES_START) w_next_state = ST_LOAD;
      ST_LOAD:     w_next_state = ST_KEYEXP;
      ST_KEYEXP:   if (KEY_EXP_DONE) w_next_state = ST_ARK_INIT;
      ST_ARK_INIT: w_next_state = ST_ISR;
      ST_ISR:      w_next_state = ST_ISB;
      ST_ISB:      w_next_state = ST_ARK;
      ST_ARK:      w_next_state = ST_IMC;
      ST_IMC: begin
        if (r_col == LAST_COL)
          w_next_state = (r_round > 4'd1) ? ST_ISR : ST_FIN_ISR;
      end
      ST_FIN_ISR:  w_next_state = ST_FIN_ISB;
      ST_FIN_ISB:  w_next_state = ST_FIN_ARK;
      ST_FIN_ARK:  w_next_state = ST_DONE;
      ST_DONE:     if (!AES_START) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state and counters, so no input reaches an
  // output combinationally and reset forces them to their idle values at once.
  always_comb begin
    w_op        = OP_HOLD;
    w_round_idx = r_round;
    w_mix_col   = 2'd0;
    w_key_start = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE:     w_busy = 1'b0;
      ST_LOAD:     w_op = OP_LOAD_MSG;
      ST_KEYEXP:   w_key_start = 1'b1;
      ST_ARK_INIT: begin
        w_op        = OP_ADD_RK;
        w_round_idx = LAST_KEY;
      end
      ST_ISR, ST_FIN_ISR: w_op = OP_INV_SHIFT;
      ST_ISB, ST_FIN_ISB: w_op = OP_INV_SUB;
      ST_ARK:      w_op = OP_ADD_RK;
      ST_IMC: begin
        w_op      = OP_INV_MIX;
        w_mix_col = r_col;
      end
      ST_FIN_ARK: begin
        w_op        = OP_ADD_RK;
        w_round_idx = 4'd0;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_busy = 1'b0;
      end
      default:     w_busy = 1'b0;
    endcase
  end

  assign OP_SEL        = w_op;
  assign STATE_LD      = (w_op != OP_HOLD);
  assign ROUND_IDX     = w_round_idx;
  assign MIX_COL_IDX   = w_mix_col;
  assign KEY_EXP_START = w_key_start;
  assign AES_DONE      = w_done;
  assign BUSY          = w_busy;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: nominal run, DONE hold, ignored
// disturbances, mid-run reset and a stuck key-expansion handshake.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  logic       CLK;
  logic       RESET_N;
  logic       AES_START;
  logic       AES_DONE;
  logic       KEY_EXP_START;
  logic       KEY_EXP_DONE;
  logic [2:0] OP_SEL;
  logic       STATE_LD;
  logic [3:0] ROUND_IDX;
  logic [1:0] MIX_COL_IDX;
  logic       BUSY;

  int n_checks = 0;
  int n_errs   = 0;

  aes_round_sequencer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .KEY_EXP_START (KEY_EXP_START),
    .KEY_EXP_DONE  (KEY_EXP_DONE),
    .OP_SEL        (OP_SEL),
    .STATE_LD      (STATE_LD),
    .ROUND_IDX     (ROUND_IDX),
    .MIX_COL_IDX   (MIX_COL_IDX),
    .BUSY          (BUSY)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [12:0] out_vec();
    return {OP_SEL, STATE_LD, AES_DONE, BUSY, KEY_EXP_START, ROUND_IDX, MIX_COL_IDX};
  endfunction

  // One decryption from IDLE. kd_delay: KEYEXP cycle on which KEY_EXP_DONE is
  // raised (0 = leave it alone). abort_at: cycle after ARK_INIT to pulse reset.
  task automatic run_op(input string tag, input int kd_delay, input int exp_kexp,
                        input bit disturb, input int abort_at);
    int          kexp_n;
    int          errs;
    int          mix_n;
    int          k;
    int          rnd;
    logic [43:0] ark;
    logic [2:0]  e_op;
    logic [3:0]  e_ridx;
    logic [1:0]  e_mix;

    AES_START = 1'b1;
    tick();
    check({tag, "_load_op"}, OP_SEL, OP_LOAD_MSG);
    check({tag, "_load_busy"}, {STATE_LD, BUSY}, 2'b11);
    tick();
    kexp_n = 0;
    while (KEY_EXP_START === 1'b1 && kexp_n < 100) begin
      kexp_n++;
      if (OP_SEL !== OP_HOLD || STATE_LD !== 1'b0) kexp_n += 1000;
      if (kd_delay != 0 && kexp_n == kd_delay) KEY_EXP_DONE = 1'b1;
      tick();
      if (kd_delay != 0) KEY_EXP_DONE = 1'b0;
    end
    check({tag, "_kexp_cycles"}, kexp_n, exp_kexp);

    errs  = 0;
    mix_n = 0;
    ark   = '0;
    for (int c = 0; c < 67; c++) begin
      e_mix = 2'd0;
      if (c == 0) begin
        e_op = OP_ADD_RK; e_ridx = 4'd10;
      end else if (c <= 63) begin
        k = (c - 1) % 7;
        rnd = 9 - (c - 1) / 7;
        e_ridx = 4'(rnd);
        case (k)
          0:       e_op = OP_INV_SHIFT;
          1:       e_op = OP_INV_SUB;
          2:       e_op = OP_ADD_RK;
          default: begin e_op = OP_INV_MIX; e_mix = 2'(k - 3); end
        endcase
      end else begin
        e_ridx = 4'd1;
        case (c)
          64:      e_op = OP_INV_SHIFT;
          65:      e_op = OP_INV_SUB;
          default: begin e_op = OP_ADD_RK; e_ridx = 4'd0; end
        endcase
      end
      if (OP_SEL !== e_op || ROUND_IDX !== e_ridx || MIX_COL_IDX !== e_mix ||
          STATE_LD !== 1'b1 || BUSY !== 1'b1 || AES_DONE !== 1'b0 ||
          KEY_EXP_START !== 1'b0)
        errs++;
      if (OP_SEL === OP_ADD_RK) ark = {ark[39:0], ROUND_IDX};
      if (OP_SEL === OP_INV_MIX) mix_n++;
      if (c == abort_at) begin
        RESET_N = 1'b0;
        #1;
        check({tag, "_async_reset"}, out_vec(), 13'd0);
        AES_START = 1'b0;
        tick();
        RESET_N = 1'b1;
        check({tag, "_reset_hold"}, out_vec(), 13'd0);
        tick();
        check({tag, "_idle_after_reset"}, out_vec(), 13'd0);
        return;
      end
      if (disturb && c == 29) begin AES_START = 1'b0; KEY_EXP_DONE = 1'b1; end
      if (disturb && c == 30) begin AES_START = 1'b1; KEY_EXP_DONE = 1'b0; end
      tick();
    end
    check({tag, "_seq_errs"}, errs, 0);
    check({tag, "_ark_trace"}, ark, 44'hA9876543210);
    check({tag, "_mix_count"}, mix_n, 36);
    check({tag, "_done_at_67"}, {AES_DONE, BUSY, OP_SEL, STATE_LD}, {1'b1, 1'b0, 3'd0, 1'b0});
  endtask

  task automatic finish_done(input string tag, input int hold);
    int errs = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (AES_DONE !== 1'b1 || OP_SEL !== OP_HOLD || BUSY !== 1'b0) errs++;
    end
    check({tag, "_done_hold"}, errs, 0);
    AES_START = 1'b0;
    tick();
    check({tag, "_back_idle"}, {AES_DONE, BUSY, OP_SEL}, 5'd0);
  endtask

  initial begin
    RESET_N      = 1'b0;
    AES_START    = 1'b0;
    KEY_EXP_DONE = 1'b0;
    #1;
    check("por_outputs", out_vec(), 13'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check("idle_no_start", {BUSY, OP_SEL}, 4'd0);

    run_op("nominal", 5, 5, 1'b0, -1);
    finish_done("nominal", 20);

    run_op("disturb", 3, 3, 1'b1, -1);
    finish_done("disturb", 2);

    // Reset during round 4 (cycle 38 after ARK_INIT is its ARK step).
    run_op("abort", 2, 2, 1'b0, 38);
    run_op("post_reset", 4, 4, 1'b0, -1);
    finish_done("post_reset", 2);

    KEY_EXP_DONE = 1'b1;
    tick();
    run_op("kd_stuck", 0, 1, 1'b0, -1);
    KEY_EXP_DONE = 1'b0;
    finish_done("kd_stuck", 2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-low.
REQ-002 SHALL expose ports (name direction width meaning):
- CLK  in  1  system clock, 50 MHz, rising-edge.
- RESET_N  in  1  asynchronous active-low reset.
- AES_START  in  1  level request to decrypt the loaded message.
- AES_DONE  out  1  result valid; held until AES_START falls.
- KEY_EXP_START  out  1  held high while waiting on key expansion.
- KEY_EXP_DONE  in  1  key schedule ready; sampled only in KEYEXP.
- OP_SEL  out  3  datapath op: 0 HOLD, 1 LOAD_MSG, 2 ADD_RK, 3 INV_SHIFT, 4 INV_SUB, 5 INV_MIX.
- STATE_LD  out  1  state register load enable; high iff OP_SEL != HOLD.
- ROUND_IDX  out  4  round-key index used by ADD_RK, 10 down to 0.
- MIX_COL_IDX  out  2  column index for INV_MIX, 0..3.
- BUSY  out  1  high in every state except IDLE and DONE.

Function
REQ-003 SHALL implement the FSM states IDLE, LOAD, KEYEXP, ARK_INIT, ISR, ISB, ARK, IMC, FIN_ISR, FIN_ISB, FIN_ARK, DONE.
REQ-004 IDLE SHALL go to LOAD when AES_START=1 is sampled, and SHALL otherwise stay in IDLE.
REQ-005 LOAD SHALL last 1 cycle with OP_SEL=LOAD_MSG, then go to KEYEXP.
REQ-006 KEYEXP SHALL hold KEY_EXP_START=1 and OP_SEL=HOLD, SHALL wait with no timeout, and SHALL go to ARK_INIT on the cycle KEY_EXP_DONE=1 is sampled.
REQ-007 ARK_INIT SHALL last 1 cycle with OP_SEL=ADD_RK and ROUND_IDX=10, then set the round counter to 9 and go to ISR.
REQ-008 Each middle round SHALL run ISR(1 cycle), ISB(1), ARK(1, ROUND_IDX=counter), then IMC(4 cycles, MIX_COL_IDX 0,1,2,3), for 7 cycles per round.
REQ-009 After IMC with MIX_COL_IDX=3: if counter>1, SHALL decrement the counter and go to ISR; if counter=1, SHALL go to FIN_ISR.
REQ-010 FIN_ISR, FIN_ISB and FIN_ARK SHALL each last 1 cycle; FIN_ARK SHALL use ROUND_IDX=0; then SHALL go to DONE.
REQ-011 Latency SHALL be exactly 67 cycles from the first ARK_INIT cycle to the first DONE cycle (1 + 9*7 + 3).
REQ-012 DONE SHALL drive AES_DONE=1 and OP_SEL=HOLD, and SHALL go to IDLE on the first cycle AES_START=0 is sampled.
REQ-013 From DONE to IDLE SHALL take 1 cycle; AES_START held high SHALL NOT retrigger.
REQ-014 A change on AES_START while BUSY=1 SHALL be ignored; the operation SHALL run to DONE.
REQ-015 KEY_EXP_DONE outside KEYEXP SHALL be ignored.
REQ-016 ROUND_IDX SHALL stay at the counter value outside ADD_RK states.
REQ-017 MIX_COL_IDX SHALL be 0 outside IMC.
REQ-018 All outputs SHALL be registered or pure decodes of the state register; there SHALL be no combinational path from an input to an output.

Reset
REQ-019 RESET_N=0 SHALL force IDLE immediately, mid-operation included.
REQ-020 Reset values SHALL be: OP_SEL=HOLD, STATE_LD=0, AES_DONE=0, BUSY=0, KEY_EXP_START=0, ROUND_IDX=0, MIX_COL_IDX=0, round counter=0.
REQ-021 After RESET_N rises, AES_START=1 sampled SHALL start a fresh LOAD.

Structure
REQ-022 The op-select enum, FSM state enum, NUM_ROUNDS=10 and IMC_COLS=4 SHALL live in shared package aes_pkg.
REQ-023 The block SHALL be one module: FSM, round counter and column counter, with no sub-module.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- Nominal: KEY_EXP_DONE 5 cycles after KEYEXP entry -> ADD_RK ROUND_IDX sequence 10,9..1,0; 36 INV_MIX cycles; AES_DONE 67 cycles after ARK_INIT.
- With the aes datapath, key 000102030405060708090a0b0c0d0e0f and ciphertext daec3055df058e1c39e814ea76f6747e -> AES_MSG_DEC equals the known plaintext at AES_DONE.
- AES_START held high 20 cycles into DONE -> AES_DONE stays 1 with no new LOAD; after START falls -> IDLE next cycle.
- AES_START toggled during round 5 and KEY_EXP_DONE pulsed in ISB -> sequence and latency unchanged.
- RESET_N low for 1 cycle at round 4 -> all outputs at reset values immediately; next START -> full 67-cycle run.
- KEY_EXP_DONE stuck at 1 before START -> KEYEXP lasts exactly 1 cycle.
